alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_ctrl_decode.sv | 27 ++
 rtl/alu_datapath.sv | 34 +++
 rtl/alu_issue.sv | 103 ++++++++++
 tb/tb_alu_issue.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation modes, decode constants and operand field widths.
package alu_pkg;

   localparam int unsigned ModeW  = 5;
   localparam int unsigned ShamtW = 5;
   localparam int unsigned TagW   = 5;
   localparam int unsigned Funct3W = 3;

   typedef logic [ModeW-1:0] alu_mode_t;

   // mode = {sub_bit, 1'b0, funct3}
   localparam alu_mode_t MODE_ADD  = 5'h00;
   localparam alu_mode_t MODE_SUB  = 5'h10;
   localparam alu_mode_t MODE_XOR  = 5'h04;
   localparam alu_mode_t MODE_OR   = 5'h06;
   localparam alu_mode_t MODE_AND  = 5'h07;
   localparam alu_mode_t MODE_SLL  = 5'h01;
   localparam alu_mode_t MODE_SRL  = 5'h05;
   localparam alu_mode_t MODE_SRA  = 5'h15;
   localparam alu_mode_t MODE_SLT  = 5'h02;
   localparam alu_mode_t MODE_SLTU = 5'h03;

   localparam logic [Funct3W-1:0] F3_ADD = 3'd0;
   localparam logic [Funct3W-1:0] F3_SR  = 3'd5;

   function automatic alu_mode_t make_mode(input logic sub_bit, input logic [Funct3W-1:0] funct3);
      return {sub_bit, 1'b0, funct3};
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Control decode: funct3/funct7_5/is_imm to ALU mode plus illegal-encoding flag.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [Funct3W-1:0] funct3,
   input  logic               funct7_5,
   input  logic               is_imm,
   output alu_mode_t          mode_c,
   output logic               illegal_c
);

   logic sub_bit;

   // The modifier only selects SUB (reg-reg add) or SRA; an immediate add ignores it.
   always_comb begin
      sub_bit   = 1'b0;
      illegal_c = 1'b0;
      if (((funct3 == F3_ADD) && !is_imm) || (funct3 == F3_SR)) begin
         sub_bit = funct7_5;
      end
      if (funct7_5 && (funct3 != F3_ADD) && (funct3 != F3_SR)) begin
         illegal_c = 1'b1;
      end
      mode_c = make_mode(sub_bit, funct3);
   end

endmodule

// File: rtl/alu_datapath.sv
// Combinational ALU datapath shared with other issue blocks.
module alu_datapath
   import alu_pkg::*;
#(
   parameter int unsigned WordSize = 32
) (
   input  alu_mode_t           mode,
   input  logic [WordSize-1:0] a,
   input  logic [WordSize-1:0] b,
   output logic [WordSize-1:0] result_c
);

   logic [ShamtW-1:0] shamt;

   assign shamt = b[ShamtW-1:0];

   always_comb begin
      result_c = '0;
      case (mode)
         MODE_ADD:  result_c = a + b;
         MODE_SUB:  result_c = a - b;
         MODE_XOR:  result_c = a ^ b;
         MODE_OR:   result_c = a | b;
         MODE_AND:  result_c = a & b;
         MODE_SLL:  result_c = a << shamt;
         MODE_SRL:  result_c = a >> shamt;
         MODE_SRA:  result_c = WordSize'($signed(a) >>> shamt);
         MODE_SLT:  result_c = WordSize'($signed(a) < $signed(b));
         MODE_SLTU: result_c = WordSize'(a < b);
         default:   result_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// Two-stage ALU issue pipeline: stage 1 holds decoded op, stage 2 holds the result.
module alu_issue
   import alu_pkg::*;
#(
   parameter int unsigned WordSize = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [Funct3W-1:0]  funct3,
   input  logic                funct7_5,
   input  logic                is_imm,
   input  logic [WordSize-1:0] rs1_data,
   input  logic [WordSize-1:0] rs2_data,
   input  logic [WordSize-1:0] imm,
   input  logic [TagW-1:0]     rd_in,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WordSize-1:0] out_data,
   output logic [TagW-1:0]     out_rd,
   output logic                out_illegal
);

   alu_mode_t           dec_mode_c;
   logic                dec_illegal_c;
   logic [WordSize-1:0] alu_result_c;

   logic                s1_valid;
   alu_mode_t           s1_mode;
   logic [WordSize-1:0] s1_a;
   logic [WordSize-1:0] s1_b;
   logic [TagW-1:0]     s1_rd;
   logic                s1_illegal;

   logic                adv2_c;
   logic                adv1_c;
   logic                accept_c;

   alu_ctrl_decode u_decode (
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .is_imm    (is_imm),
      .mode_c    (dec_mode_c),
      .illegal_c (dec_illegal_c)
   );

   alu_datapath #(
      .WordSize (WordSize)
   ) u_datapath (
      .mode     (s1_mode),
      .a        (s1_a),
      .b        (s1_b),
      .result_c (alu_result_c)
   );

   // Backpressure chain; out_ready ripples combinationally into in_ready.
   always_comb begin
      adv2_c   = !out_valid || out_ready;
      adv1_c   = adv2_c || !s1_valid;
      in_ready = !rst && !flush && adv1_c;
      accept_c = in_valid && in_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_mode     <= MODE_ADD;
         s1_a        <= '0;
         s1_b        <= '0;
         s1_rd       <= '0;
         s1_illegal  <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_rd      <= '0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (adv2_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data    <= s1_illegal ? '0 : alu_result_c;
               out_rd      <= s1_rd;
               out_illegal <= s1_illegal;
            end
         end
         if (adv1_c) begin
            s1_valid <= accept_c;
            if (accept_c) begin
               s1_mode    <= dec_mode_c;
               s1_a       <= rs1_data;
               s1_b       <= is_imm ? imm : rs2_data;
               s1_rd      <= rd_in;
               s1_illegal <= dec_illegal_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed corner cases plus randomized traffic vs. a reference model.
module tb_alu_issue;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   funct3;
   logic         funct7_5;
   logic         is_imm;
   logic [W-1:0] rs1_data;
   logic [W-1:0] rs2_data;
   logic [W-1:0] imm;
   logic [4:0]   rd_in;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [4:0]   out_rd;
   logic         out_illegal;

   always #5 clk = ~clk;

   alu_issue #(.WordSize(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .is_imm      (is_imm),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .imm         (imm),
      .rd_in       (rd_in),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: returns {illegal, data} straight from the operation definitions.
   function automatic logic [W:0] ref_op(input logic [2:0] f3, input logic f75, input logic ii,
                                         input logic [W-1:0] a, input logic [W-1:0] r2,
                                         input logic [W-1:0] im);
      logic [W-1:0] b;
      logic [W-1:0] r;
      longint       sa;
      longint       sb;
      int unsigned  sh;
      b  = ii ? im : r2;
      sh = 32'(b[4:0]);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (f75 && f3 != 3'd0 && f3 != 3'd5) return {1'b1, {W{1'b0}}};
      case (f3)
         3'd0:    r = (f75 && !ii) ? a - b : a + b;
         3'd1:    r = W'(64'(a) * (64'd1 << sh));
         3'd2:    r = (sa < sb) ? 1 : 0;
         3'd3:    r = (64'(a) < 64'(b)) ? 1 : 0;
         3'd4:    r = a ^ b;
         3'd5:    r = f75 ? W'(sa >>> sh) : W'(64'(a) / (64'd1 << sh));
         3'd6:    r = a | b;
         default: r = a & b;
      endcase
      return {1'b0, r};
   endfunction

   typedef struct {
      logic [W-1:0] data;
      logic [4:0]   rd;
      logic         ill;
   } exp_t;

   exp_t sb_q[$];
   logic hold_pend = 1'b0;

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge clk) begin
      logic [W:0] e;
      exp_t       x;
      if (rst) begin
         sb_q.delete();
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) check("hold_valid", out_valid, 1'b1);
         hold_pend = 1'b0;
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               check("spurious_out", out_valid, 1'b0);
            end else begin
               check("out_data", out_data, sb_q[0].data);
               check("out_rd", out_rd, sb_q[0].rd);
               check("out_illegal", out_illegal, sb_q[0].ill);
               if (out_ready) void'(sb_q.pop_front());
               else if (!flush) hold_pend = 1'b1;
            end
         end
         if (flush) begin
            check("flush_in_ready", in_ready, 1'b0);
            sb_q.delete();
         end else if (in_valid && in_ready) begin
            e = ref_op(funct3, funct7_5, is_imm, rs1_data, rs2_data, imm);
            x.data = e[W-1:0];
            x.rd   = rd_in;
            x.ill  = e[W];
            sb_q.push_back(x);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [2:0] f3, input logic f75, input logic ii,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] im);
      funct3   = f3;
      funct7_5 = f75;
      is_imm   = ii;
      rs1_data = a;
      rs2_data = b;
      imm      = im;
      rd_in    = 5'($urandom);
   endtask

   // Single op with fixed two-cycle latency check and expected result.
   task automatic run_one(input string tag, input logic [2:0] f3, input logic f75, input logic ii,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] im,
                          input logic [W-1:0] exp_data, input logic exp_ill);
      logic [4:0] rd;
      set_op(f3, f75, ii, a, b, im);
      rd       = rd_in;
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_accept"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_lat1"}, out_valid, 1'b0);
      @(negedge clk);
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_data"}, out_data, exp_data);
      check({tag, "_ill"}, out_illegal, exp_ill);
      check({tag, "_rd"}, out_rd, rd);
      tick();
   endtask

   function automatic logic [W-1:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 40));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      set_op(3'd0, 1'b0, 1'b0, '0, '0, '0);
      tick(); tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_rd", out_rd, '0);
      check("rst_out_ill", out_illegal, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      tick();

      run_one("add", 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, '0, 32'd12, 1'b0);
      run_one("addi_f75", 3'd0, 1'b1, 1'b1, 32'd3, 32'd99, 32'hFFFF_FFFF, 32'd2, 1'b0);
      run_one("sra", 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4, '0, 32'hF800_0000, 1'b0);
      run_one("srl", 3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd4, '0, 32'h0800_0000, 1'b0);
      run_one("slt", 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, '0, 32'd1, 1'b0);
      run_one("sub", 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, '0, 32'hFFFF_FFFE, 1'b0);
      run_one("illegal_xor", 3'd4, 1'b1, 1'b0, 32'h1234, 32'h00FF, '0, 32'd0, 1'b1);

      // Backpressure: two accepts fill the pipe, third waits for release.
      out_ready = 1'b0;
      set_op(3'd0, 1'b0, 1'b0, 32'd10, 32'd1, '0); in_valid = 1'b1;
      @(negedge clk); check("bp_acc_a", in_ready, 1'b1);
      tick();
      set_op(3'd6, 1'b0, 1'b0, 32'hF0, 32'h0F, '0);
      @(negedge clk); check("bp_acc_b", in_ready, 1'b1);
      tick();
      set_op(3'd1, 1'b0, 1'b1, 32'd1, '0, 32'd31);
      @(negedge clk); check("bp_stall_0", in_ready, 1'b0);
      tick();
      @(negedge clk); check("bp_stall_1", in_ready, 1'b0);
      tick();
      out_ready = 1'b1;
      @(negedge clk); check("bp_acc_c", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      check("bp_drained", 64'(sb_q.size()), 64'd0);
      check("bp_idle", out_valid, 1'b0);

      // Flush with two ops in flight.
      out_ready = 1'b0;
      set_op(3'd4, 1'b0, 1'b0, 32'hAA, 32'h55, '0); in_valid = 1'b1;
      tick();
      set_op(3'd7, 1'b0, 1'b0, 32'hAA, 32'hFF, '0);
      tick();
      set_op(3'd3, 1'b0, 1'b0, 32'd1, 32'd2, '0);
      flush = 1'b1;
      @(negedge clk); check("flush_rdy_low", in_ready, 1'b0);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); check("flush_no_out", out_valid, 1'b0);
         tick();
      end

      // Reset one cycle after an accept.
      set_op(3'd0, 1'b0, 1'b0, 32'd1, 32'd1, '0); in_valid = 1'b1;
      tick();
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk); check("rstmid_out0", out_valid, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk); check("rstmid_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); check("rstmid_no_out", out_valid, 1'b0);
      end
      tick();

      // Randomized traffic with backpressure, flush and occasional reset.
      for (int c = 0; c < 600; c++) begin
         set_op(3'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                rand_word(), rand_word(), rand_word());
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         tick();
      end
      in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 20 && (sb_q.size() != 0 || out_valid); c++) tick();
      check("final_drain", 64'(sb_q.size()), 64'd0);
      @(negedge clk); check("final_idle", out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
